// File: rtl/rule_cfg_master.sv
// Rule-bus initiator: turns host WRITE/READ/FILL commands into rule wren/rden pulses and returns one response per command.
// Define RULE_CFG_READBACK_CHK_EN to read back and compare every written beat.
module rule_cfg_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [1:0]        o_rsp_status,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rule_wren,
  output logic              o_rule_rden,
  output logic [ADDR_W-1:0] o_rule_addr,
  output logic [DATA_W-1:0] o_rule_wdata,
  input  logic              i_rule_rdata_valid,
  input  logic [DATA_W-1:0] i_rule_rdata
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TIMEOUT  = 2'd1;
  localparam logic [1:0] ST_BADOP    = 2'd2;
  localparam logic [1:0] ST_MISMATCH = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_FILL, S_RD, S_RD_WAIT, S_RSP} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beats;
  logic [TO_W-1:0]   r_to_cnt;
  logic [1:0]        r_rsp_status;
  logic [DATA_W-1:0] r_rsp_data;

  logic             w_accept;
  logic             w_fill_last;
  logic             w_to_last;
  logic [LEN_W-1:0] w_beats_inc;

  assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
  assign w_fill_last = (r_beats == r_len - LEN_W'(1));
  assign w_to_last   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_beats_inc = r_beats + LEN_W'(1);

`ifdef RULE_CFG_READBACK_CHK_EN
  logic w_rb_match;
  assign w_rb_match = (i_rule_rdata == r_wdata);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_cmd_op)
            OP_WRITE: w_next = S_WR;
            OP_READ:  w_next = S_RD;
            OP_FILL:  w_next = (i_cmd_len == '0) ? S_RSP : S_FILL;
            default:  w_next = S_RSP;
          endcase
        end
      end
`ifdef RULE_CFG_READBACK_CHK_EN
      S_WR:   w_next = S_RD;
      S_FILL: w_next = S_RD;
`else
      S_WR:   w_next = S_RSP;
      S_FILL: w_next = w_fill_last ? S_RSP : S_FILL;
`endif
      S_RD:   w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (i_rule_rdata_valid) begin
`ifdef RULE_CFG_READBACK_CHK_EN
          // A passing readback of a non-final FILL beat continues with the next write.
          if (r_op == OP_FILL && w_rb_match && !w_fill_last) w_next = S_FILL;
          else                                                w_next = S_RSP;
`else
          w_next = S_RSP;
`endif
        end else if (w_to_last) begin
          w_next = S_RSP;
        end
      end
      S_RSP:   if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_len        <= '0;
      r_beats      <= '0;
      r_to_cnt     <= '0;
      r_rsp_status <= ST_OK;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op         <= i_cmd_op;
            r_addr       <= i_cmd_addr;
            r_wdata      <= i_cmd_wdata;
            r_len        <= i_cmd_len;
            r_beats      <= '0;
            r_rsp_status <= (i_cmd_op == 2'd3) ? ST_BADOP : ST_OK;
            r_rsp_data   <= '0;
          end
        end
`ifndef RULE_CFG_READBACK_CHK_EN
        S_FILL: begin
          r_addr     <= r_addr + ADDR_W'(1);
          r_beats    <= w_beats_inc;
          r_rsp_data <= DATA_W'(w_beats_inc);
        end
`endif
        S_RD: r_to_cnt <= '0;
        S_RD_WAIT: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (i_rule_rdata_valid) begin
            if (r_op == OP_READ) begin
              r_rsp_status <= ST_OK;
              r_rsp_data   <= i_rule_rdata;
            end
`ifdef RULE_CFG_READBACK_CHK_EN
            else if (w_rb_match) begin
              if (r_op == OP_FILL) begin
                r_addr     <= r_addr + ADDR_W'(1);
                r_beats    <= w_beats_inc;
                r_rsp_data <= DATA_W'(w_beats_inc);
              end
            end else begin
              r_rsp_status <= ST_MISMATCH;
              r_rsp_data   <= (r_op == OP_WRITE) ? i_rule_rdata : DATA_W'(r_beats);
            end
`endif
          end else if (w_to_last) begin
            r_rsp_status <= ST_TIMEOUT;
            r_rsp_data   <= (r_op == OP_FILL) ? DATA_W'(r_beats) : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_rsp_valid  = (r_state == S_RSP);
  assign o_rsp_status = r_rsp_status;
  assign o_rsp_data   = r_rsp_data;
  assign o_rule_wren  = (r_state == S_WR) || (r_state == S_FILL);
  assign o_rule_rden  = (r_state == S_RD);
  assign o_rule_addr  = r_addr;
  assign o_rule_wdata = r_wdata;

endmodule

// File: tb/tb_rule_cfg_master.sv
// Directed self-checking bench for rule_cfg_master; a negedge process logs bus pulses and plays the rule responder.
module tb_rule_cfg_master;
  localparam int AW = 32, DW = 32, LW = 8, TO = 16;

  logic          i_clk = 1'b0, i_rst = 1'b1;
  logic          i_cmd_valid = 1'b0, i_rsp_ready = 1'b0;
  logic [1:0]    i_cmd_op = '0;
  logic [AW-1:0] i_cmd_addr = '0;
  logic [DW-1:0] i_cmd_wdata = '0;
  logic [LW-1:0] i_cmd_len = '0;
  logic          i_rule_rdata_valid = 1'b0;
  logic [DW-1:0] i_rule_rdata = '0;
  logic          o_cmd_ready, o_rsp_valid, o_rule_wren, o_rule_rden;
  logic [1:0]    o_rsp_status;
  logic [DW-1:0] o_rsp_data, o_rule_wdata;
  logic [AW-1:0] o_rule_addr;

  rule_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_len(i_cmd_len),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_status(o_rsp_status),
    .o_rsp_data(o_rsp_data), .o_rule_wren(o_rule_wren), .o_rule_rden(o_rule_rden),
    .o_rule_addr(o_rule_addr), .o_rule_wdata(o_rule_wdata),
    .i_rule_rdata_valid(i_rule_rdata_valid), .i_rule_rdata(i_rule_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus log and responder state.
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            rd_cnt = 0, rd_cyc = -1;
  bit            both_seen = 0;
  int            rsp_mode = 0;      // 0 silent, 1 fixed value, 2 echo last write
  int            rsp_delay = 3;
  logic [DW-1:0] rsp_val = '0;
  bit            early_junk = 0, late_pulse = 0;
  int            rd_idx = 0, corrupt_idx = -1, due = -1;
  logic [DW-1:0] due_val = '0, last_wdata = '0;

  always @(negedge i_clk) begin
    i_rule_rdata_valid = 1'b0;
    i_rule_rdata       = '0;
    if (o_rule_wren) begin
      wr_addr_q.push_back(o_rule_addr);
      wr_data_q.push_back(o_rule_wdata);
      wr_cyc_q.push_back(cyc);
      last_wdata = o_rule_wdata;
    end
    if (o_rule_wren && o_rule_rden) both_seen = 1;
    if (o_rule_rden) begin rd_cnt++; rd_cyc = cyc; end
    if (due == cyc) begin
      i_rule_rdata_valid = 1'b1;
      i_rule_rdata       = due_val;
      due = -1;
    end
    if (o_rule_rden && rsp_mode != 0) begin
      rd_idx++;
      due     = cyc + rsp_delay;
      due_val = (rsp_mode == 1) ? rsp_val : ((rd_idx == corrupt_idx) ? ~last_wdata : last_wdata);
      if (early_junk) begin i_rule_rdata_valid = 1'b1; i_rule_rdata = 32'hDEAD; end
    end
    if (late_pulse) begin
      i_rule_rdata_valid = 1'b1;
      i_rule_rdata       = 32'h0BAD;
      late_pulse = 0;
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_cnt = 0; rd_cyc = -1; rd_idx = 0;
  endtask

  // Present a command for one cycle; t is the cycle count before the accepting edge.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [LW-1:0] len, output int t);
    check("cmd_ready_idle", o_cmd_ready, 1);
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_len = len;
    t = cyc;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (o_rsp_valid) begin at = cyc; break; end
      tick();
    end
    check("rsp_seen", o_rsp_valid, 1);
  endtask

  task automatic finish_rsp();
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("ready_after_rsp", o_cmd_ready, 1);
  endtask

  function automatic logic [63:0] qa(input int i);
    return (i < wr_addr_q.size()) ? 64'(wr_addr_q[i]) : 64'hx;
  endfunction
  function automatic logic [63:0] qd(input int i);
    return (i < wr_data_q.size()) ? 64'(wr_data_q[i]) : 64'hx;
  endfunction
  function automatic logic [63:0] qc(input int i);
    return (i < wr_cyc_q.size()) ? 64'(wr_cyc_q[i]) : 64'hx;
  endfunction

  initial begin
    int t, at;
    bit stable;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, at;
    bit stable;
    repeat (3) tick();
    check("rst_wren", o_rule_wren, 0);
    check("rst_rden", o_rule_rden, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_addr", o_rule_addr, 0);
    check("rst_wdata", o_rule_wdata, 0);
    check("rst_rsp_data", o_rsp_data, 0);
    i_rst = 1'b0;
    tick();
    check("post_rst_ready", o_cmd_ready, 1);

    // READ with a junk valid during the rden cycle, real data 3 cycles after rden.
    clear_log(); rsp_mode = 1; rsp_delay = 3; rsp_val = 32'hCAFE; early_junk = 1;
    send(2'd1, 32'h5, '0, '0, t);
    wait_rsp(at);
    early_junk = 0;
    check("rd_count", rd_cnt, 1);
    check("rd_cycle", rd_cyc, t + 1);
    check("rd_no_wren", wr_addr_q.size(), 0);
    check("rd_rsp_cycle", at, t + 5);
    check("rd_status", o_rsp_status, 0);
    check("rd_data", o_rsp_data, 32'hCAFE);
    finish_rsp();

    // READ answered on the last RD_WAIT cycle still succeeds.
    clear_log(); rsp_mode = 1; rsp_delay = TO; rsp_val = 32'h1234;
    send(2'd1, 32'h6, '0, '0, t);
    wait_rsp(at);
    check("rd_edge_cycle", at, t + 2 + TO);
    check("rd_edge_status", o_rsp_status, 0);
    check("rd_edge_data", o_rsp_data, 32'h1234);
    finish_rsp();

    // READ timeout, then late valids in RSP and IDLE are ignored.
    clear_log(); rsp_mode = 0;
    send(2'd1, 32'h9, '0, '0, t);
    wait_rsp(at);
    check("to_cycle", at, t + 2 + TO);
    check("to_status", o_rsp_status, 1);
    check("to_data", o_rsp_data, 0);
    late_pulse = 1; tick(); tick();
    check("to_late_status", o_rsp_status, 1);
    check("to_late_data", o_rsp_data, 0);
    finish_rsp();
    late_pulse = 1; tick(); tick();
    check("idle_late_no_rsp", o_rsp_valid, 0);

    // Reserved op with the response held off for 10 cycles.
    clear_log();
    send(2'd3, 32'h77, 32'h88, 8'd5, t);
    wait_rsp(at);
    check("badop_cycle", at, t + 1);
    check("badop_status", o_rsp_status, 2);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(o_rsp_valid && o_rsp_status == 2'd2 && o_rsp_data == '0 && !o_cmd_ready &&
            !o_rule_wren && !o_rule_rden)) stable = 0;
    end
    check("badop_hold_stable", stable, 1);
    check("badop_no_pulses", wr_addr_q.size() + rd_cnt, 0);
    finish_rsp();

`ifndef RULE_CFG_READBACK_CHK_EN
    // Single WRITE.
    clear_log();
    send(2'd0, 32'h0100_0302, 32'h1_0305, '0, t);
    wait_rsp(at);
    check("wr_count", wr_addr_q.size(), 1);
    check("wr_addr", qa(0), 32'h0100_0302);
    check("wr_wdata", qd(0), 32'h1_0305);
    check("wr_cycle", qc(0), t + 1);
    check("wr_rsp_cycle", at, t + 2);
    check("wr_status", o_rsp_status, 0);
    check("wr_data", o_rsp_data, 0);
    finish_rsp();

    // FILL wrapping across the top of the address space.
    clear_log();
    send(2'd2, 32'hFFFF_FFFE, 32'hA5, 8'd4, t);
    wait_rsp(at);
    check("fill_count", wr_addr_q.size(), 4);
    check("fill_addr0", qa(0), 32'hFFFF_FFFE);
    check("fill_addr1", qa(1), 32'hFFFF_FFFF);
    check("fill_addr2", qa(2), 32'h0);
    check("fill_addr3", qa(3), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_wdata%0d", i), qd(i), 32'hA5);
      check($sformatf("fill_cyc%0d", i), qc(i), t + 1 + i);
    end
    check("fill_rsp_cycle", at, t + 5);
    check("fill_status", o_rsp_status, 0);
    check("fill_data", o_rsp_data, 4);
    finish_rsp();

    // FILL with zero length.
    clear_log();
    send(2'd2, 32'h10, 32'h1, 8'd0, t);
    wait_rsp(at);
    check("fill0_cycle", at, t + 1);
    check("fill0_status", o_rsp_status, 0);
    check("fill0_data", o_rsp_data, 0);
    check("fill0_no_wren", wr_addr_q.size(), 0);
    finish_rsp();

    // Reset in the middle of a long FILL.
    clear_log();
    send(2'd2, 32'h20, 32'h55, 8'd10, t);
    tick(); tick();
    check("midrst_beats_before", wr_addr_q.size(), 3);
    i_rst = 1'b1;
    tick();
    check("midrst_wren", o_rule_wren, 0);
    check("midrst_addr", o_rule_addr, 0);
    check("midrst_wdata", o_rule_wdata, 0);
    check("midrst_rsp_valid", o_rsp_valid, 0);
    tick();
    i_rst = 1'b0;
    stable = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_rsp_valid) stable = 0;
    end
    check("midrst_no_rsp", stable, 1);
    check("midrst_no_more_beats", wr_addr_q.size(), 3);
    check("midrst_ready", o_cmd_ready, 1);
`else
    // Readback FILL with the second readback corrupted.
    clear_log(); rsp_mode = 2; rsp_delay = 1; corrupt_idx = 2;
    send(2'd2, 32'h40, 32'h77, 8'd3, t);
    wait_rsp(at);
    check("rb_fill_status", o_rsp_status, 3);
    check("rb_fill_data", o_rsp_data, 1);
    check("rb_fill_wr_count", wr_addr_q.size(), 2);
    check("rb_fill_rd_count", rd_cnt, 2);
    check("rb_fill_addr1", qa(1), 32'h41);
    finish_rsp();

    // Readback WRITE mismatch returns the value read.
    clear_log(); corrupt_idx = 1;
    send(2'd0, 32'h7, 32'h0F0F, '0, t);
    wait_rsp(at);
    check("rb_wr_status", o_rsp_status, 3);
    check("rb_wr_data", o_rsp_data, 32'hFFFF_F0F0);
    check("rb_wr_count", wr_addr_q.size(), 1);
    finish_rsp();

    // Readback FILL where every beat matches.
    clear_log(); corrupt_idx = -1;
    send(2'd2, 32'h50, 32'h3C, 8'd2, t);
    wait_rsp(at);
    check("rb_ok_status", o_rsp_status, 0);
    check("rb_ok_data", o_rsp_data, 2);
    check("rb_ok_addr1", qa(1), 32'h51);
    finish_rsp();
`endif

    check("wr_rd_exclusive", both_seen, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
